// File: rtl/bsg_vanilla_pkg.sv
// bsg_vanilla_pkg: shared vanilla-core widths, divide opcodes and divider FSM states.
package bsg_vanilla_pkg;

    localparam int RV32_reg_data_width_gp = 32;
    localparam int RV32_reg_addr_width_gp = 5;

    typedef enum logic [1:0] {eDIV, eDIVU, eREM, eREMU} idiv_op_e;

    typedef enum logic [1:0] {eIDIV_IDLE, eIDIV_CALC, eIDIV_DONE} idiv_state_e;

endpackage

// File: rtl/bsg_vanilla_idiv_step.sv
// bsg_vanilla_idiv_step: one combinational restoring shift/subtract step.
// The 33-bit compare lets divisors and partial remainders at or above 2^31 resolve correctly.
module bsg_vanilla_idiv_step
    import bsg_vanilla_pkg::*;
#(
    parameter int data_width_p = RV32_reg_data_width_gp
) (
    input  logic [data_width_p-1:0] rem_i,
    input  logic [data_width_p-1:0] quot_i,
    input  logic [data_width_p-1:0] div_i,
    output logic [data_width_p-1:0] rem_o,
    output logic [data_width_p-1:0] quot_o
);

    logic [data_width_p:0] sh;
    logic                  ge;

    assign sh     = {rem_i, quot_i[data_width_p-1]};
    assign ge     = sh >= {1'b0, div_i};
    assign rem_o  = ge ? sh[data_width_p-1:0] - div_i : sh[data_width_p-1:0];
    assign quot_o = {quot_i[data_width_p-2:0], ge};

endmodule

// File: rtl/bsg_vanilla_idiv_seq.sv
// bsg_vanilla_idiv_seq: iterative radix-2 DIV/DIVU/REM/REMU sequencer with sign fix-up
// and RISC-V divide-by-zero / overflow results.
module bsg_vanilla_idiv_seq
    import bsg_vanilla_pkg::*;
#(
    parameter int data_width_p     = RV32_reg_data_width_gp,
    parameter int reg_addr_width_p = RV32_reg_addr_width_gp
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        v_i,
    output logic                        ready_and_o,
    input  idiv_op_e                    op_i,
    input  logic [data_width_p-1:0]     rs1_i,
    input  logic [data_width_p-1:0]     rs2_i,
    input  logic [reg_addr_width_p-1:0] rd_i,
    output logic                        v_o,
    output logic [data_width_p-1:0]     result_o,
    output logic [reg_addr_width_p-1:0] rd_o,
    input  logic                        yumi_i
);

    localparam int cnt_w_lp = $clog2(data_width_p);

    idiv_state_e                 state_q, state_d;
    logic [cnt_w_lp-1:0]         cnt_q, cnt_d;
    logic [data_width_p-1:0]     rem_q, rem_d, quot_q, quot_d, dvs_q, dvs_d, res_q, res_d;
    logic [reg_addr_width_p-1:0] rd_q, rd_d;
    logic                        is_div_q, is_div_d, s1_q, s1_d, s2_q, s2_d;
    logic                        sgn_op, div_zero, ovf;
    logic [data_width_p-1:0]     abs1, abs2, step_rem, step_quot, quot_fix, rem_fix;

    assign sgn_op   = (op_i == eDIV) || (op_i == eREM);
    assign div_zero = rs2_i == '0;
    assign ovf      = sgn_op && (rs1_i == {1'b1, {(data_width_p-1){1'b0}}}) && (&rs2_i);
    assign abs1     = (sgn_op && rs1_i[data_width_p-1]) ? -rs1_i : rs1_i;
    assign abs2     = (sgn_op && rs2_i[data_width_p-1]) ? -rs2_i : rs2_i;

    bsg_vanilla_idiv_step #(.data_width_p(data_width_p)) step (
        .rem_i (rem_q),
        .quot_i(quot_q),
        .div_i (dvs_q),
        .rem_o (step_rem),
        .quot_o(step_quot)
    );

    // Signs are pre-masked by op type, so unsigned ops never negate.
    assign quot_fix = (s1_q ^ s2_q) ? -step_quot : step_quot;
    assign rem_fix  = s1_q ? -step_rem : step_rem;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        dvs_d    = dvs_q;
        res_d    = res_q;
        rd_d     = rd_q;
        is_div_d = is_div_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        unique case (state_q)
            eIDIV_IDLE: if (v_i) begin
                rd_d     = rd_i;
                is_div_d = (op_i == eDIV) || (op_i == eDIVU);
                s1_d     = sgn_op & rs1_i[data_width_p-1];
                s2_d     = sgn_op & rs2_i[data_width_p-1];
                rem_d    = '0;
                quot_d   = abs1;
                dvs_d    = abs2;
                cnt_d    = '0;
                state_d  = (div_zero || ovf) ? eIDIV_DONE : eIDIV_CALC;
                res_d    = div_zero ? (is_div_d ? '1 : rs1_i)
                                    : (is_div_d ? {1'b1, {(data_width_p-1){1'b0}}} : '0);
            end
            eIDIV_CALC: begin
                rem_d  = step_rem;
                quot_d = step_quot;
                cnt_d  = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = eIDIV_DONE;
                    res_d   = is_div_q ? quot_fix : rem_fix;
                end
            end
            eIDIV_DONE: state_d = yumi_i ? eIDIV_IDLE : eIDIV_DONE;
            default:    state_d = eIDIV_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= eIDIV_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            dvs_q    <= '0;
            res_q    <= '0;
            rd_q     <= '0;
            is_div_q <= 1'b0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            dvs_q    <= dvs_d;
            res_q    <= res_d;
            rd_q     <= rd_d;
            is_div_q <= is_div_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
        end
    end

    assign ready_and_o = state_q == eIDIV_IDLE;
    assign v_o         = state_q == eIDIV_DONE;
    assign result_o    = res_q;
    assign rd_o        = rd_q;

    a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule
